mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares one port of the accelerator's dual-port word memory between two requesters: requester 0 (host/mmap write path) and requester 1 (conv2d datapath). It owns the memory port's address, data and byte-enable inputs and routes the 1-cycle registered read data back to the requester that issued the read. It grants in bursts so that a requester streaming a tile keeps the port without a bubble per word.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 10, memory word-address width
- MAX_BURST, 16, max beats per grant before forced release (≥1)
- i_clk  in  1  clock, all logic on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_req_valid_0 / i_req_valid_1  in  1  request beat valid
- o_req_ready_0 / o_req_ready_1  out  1  beat accepted when valid&ready
- i_req_we_0 / i_req_we_1  in  4  byte write enables; 0 = read
- i_req_addr_0 / i_req_addr_1  in  ADDR_WIDTH  word address
- i_req_wdata_0 / i_req_wdata_1  in  DATA_WIDTH  write data
- i_req_last_0 / i_req_last_1  in  1  release grant after this beat
- o_rsp_valid_0 / o_rsp_valid_1  out  1  read data valid, one pulse per read beat
- o_rsp_rdata_0 / o_rsp_rdata_1  out  DATA_WIDTH  read data
- o_mem_we  out  4  to memory port write enable
- o_mem_addr  out  ADDR_WIDTH  to memory port address
- o_mem_din  out  DATA_WIDTH  to memory port write data
- i_mem_dout  in  DATA_WIDTH  from memory port registered read data
- o_busy  out  1  high in OWN0/OWN1 or while a read response is pending

## Operation
- States: IDLE, OWN0, OWN1 (registered). last_owner register breaks ties.
- IDLE: both ready low. Next state: only one valid → OWN of that one; both valid → OWN of the requester ≠ last_owner; none → IDLE.
- OWNn: o_req_ready_n = 1, other ready = 0. Non-owner's valid is ignored (it must hold its beat).
- Beat (valid_n & ready_n): o_mem_we/addr/din = owner's inputs combinationally that cycle; beat_cnt increments.
- No beat this cycle: o_mem_we = 0, o_mem_addr = 0, o_mem_din = 0.
- Release when a beat has last=1 or beat_cnt reaches MAX_BURST. On release: last_owner ← n, beat_cnt ← 0; next state = OWN(other) if other valid that cycle, else IDLE. Owner idling with no beat keeps the grant indefinitely.
- Read beat (we = 0): rsp_pend ← 1, rsp_id ← n. Next cycle o_rsp_valid_{rsp_id} = 1, o_rsp_rdata_{rsp_id} = i_mem_dout; other rsp_valid = 0. Write beat (we ≠ 0): no response.
- o_rsp_rdata_x = 0 whenever o_rsp_valid_x = 0.
- Memory is read-first: write and read are separate beats, so a read issued the cycle after a write to the same address returns the new data.
- beat_cnt width: clog2(MAX_BURST+1).

## Timing
- Reset (i_rstn low, any time): state IDLE, last_owner = 1 (requester 0 wins first tie), beat_cnt = 0, rsp_pend = 0; all ready, rsp_valid, rsp_rdata, o_mem_* and o_busy = 0 immediately (async). An in-flight read response is dropped.
- Grant latency from IDLE: valid seen in cycle T → ready high in T+1.
- Handover: release beat in T with other requester valid → other's ready high in T+1 (zero bubble).
- Read latency: beat accepted in T → o_rsp_valid in T+1; back-to-back reads give one response per cycle.
- Responses are in issue order; a response still emerges in T+1 even if the grant changed at T.

## Test plan
- Single read: mem[5]=0xDEADBEEF, r0 valid addr 5 last=1 in IDLE at T → ready_0 at T+1, o_mem_addr=5 at T+1, o_rsp_valid_0 with 0xDEADBEEF at T+2, state IDLE at T+2.
- Simultaneous: both valid from reset, 3-beat bursts each → r0 granted first, r1 granted immediately after r0's last beat, no idle cycle, then r0 wins the next tie only if r1 was last owner.
- Forced release: MAX_BURST=4, r1 streams 10 beats last=0, r0 valid → r1 gets 4 beats, r0 gets its burst, r1 resumes; all 10 r1 addresses reach memory in order.
- Write then read: r1 writes 0x12345678 we=4'hF to addr 0x3FF, then reads 0x3FF → rsp_valid_1 with 0x12345678; no response for the write beat.
- Reset mid-burst: assert i_rstn low during OWN1 with read pending → all outputs 0 same cycle, no response after release, first tie afterwards goes to r0.
- Owner stall: r0 owns, drops valid for 5 cycles while r1 valid → r1 ready stays 0, o_mem_we=0 and addr=0 during stall.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin burst arbiter sharing one memory port between two requesters,
// steering the registered read data back to whichever requester issued the read.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_req_valid_0,
  input  logic                  i_req_valid_1,
  output logic                  o_req_ready_0,
  output logic                  o_req_ready_1,
  input  logic [3:0]            i_req_we_0,
  input  logic [3:0]            i_req_we_1,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
  input  logic [DATA_WIDTH-1:0] i_req_wdata_0,
  input  logic [DATA_WIDTH-1:0] i_req_wdata_1,
  input  logic                  i_req_last_0,
  input  logic                  i_req_last_1,
  output logic                  o_rsp_valid_0,
  output logic                  o_rsp_valid_1,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata_0,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata_1,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic                  o_busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic last_owner_q, last_owner_d, rsp_pend_q, rsp_pend_d, rsp_id_q, rsp_id_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d, cnt_inc;
  logic own, beat, sel_last, rel, other_valid;
  logic [3:0] sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  always_comb begin
    own          = state_q == OWN1;
    sel_we       = own ? i_req_we_1 : i_req_we_0;
    sel_addr     = own ? i_req_addr_1 : i_req_addr_0;
    sel_wdata    = own ? i_req_wdata_1 : i_req_wdata_0;
    sel_last     = own ? i_req_last_1 : i_req_last_0;
    other_valid  = own ? i_req_valid_0 : i_req_valid_1;
    beat         = (state_q == OWN0 && i_req_valid_0) || (own && i_req_valid_1);
    cnt_inc      = beat_cnt_q + 1'b1;
    rel          = beat && (sel_last || cnt_inc == CW'(MAX_BURST));
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat ? cnt_inc : beat_cnt_q;
    if (state_q == IDLE)
      state_d = (i_req_valid_0 && i_req_valid_1) ? (last_owner_q ? OWN0 : OWN1) :
                i_req_valid_0 ? OWN0 : i_req_valid_1 ? OWN1 : IDLE;
    else if (rel) begin
      // hand straight to a waiting peer so streaming requesters see no bubble
      state_d      = other_valid ? (own ? OWN0 : OWN1) : IDLE;
      last_owner_d = own;
      beat_cnt_d   = '0;
    end
    rsp_pend_d = beat && sel_we == 4'h0;
    rsp_id_d   = own;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_id_q     <= rsp_id_d;
    end
  end
  assign o_req_ready_0 = state_q == OWN0;
  assign o_req_ready_1 = own;
  assign o_mem_we      = beat ? sel_we : 4'h0;
  assign o_mem_addr    = beat ? sel_addr : '0;
  assign o_mem_din     = beat ? sel_wdata : '0;
  assign o_rsp_valid_0 = rsp_pend_q && !rsp_id_q;
  assign o_rsp_valid_1 = rsp_pend_q && rsp_id_q;
  assign o_rsp_rdata_0 = o_rsp_valid_0 ? i_mem_dout : '0;
  assign o_rsp_rdata_1 = o_rsp_valid_1 ? i_mem_dout : '0;
  assign o_busy        = state_q != IDLE || rsp_pend_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and a random run against a
// transaction-level model of the arbiter plus a shadow memory.
module tb_mem_port_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] v = '0, l = '0, rdy, rv;
  logic [1:0][3:0] we = '0;
  logic [1:0][9:0] a = '0;
  logic [1:0][31:0] wd = '0;
  logic [31:0] rd0, rd1, mem_din, mem_dout;
  logic [3:0] mem_we;
  logic [9:0] mem_addr;
  logic busy;
  logic pre_we = 1'b0;
  logic [9:0] pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [31:0] mem [1024];
  int checks = 0, errors = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid_0(v[0]), .i_req_valid_1(v[1]),
    .o_req_ready_0(rdy[0]), .o_req_ready_1(rdy[1]),
    .i_req_we_0(we[0]), .i_req_we_1(we[1]),
    .i_req_addr_0(a[0]), .i_req_addr_1(a[1]),
    .i_req_wdata_0(wd[0]), .i_req_wdata_1(wd[1]),
    .i_req_last_0(l[0]), .i_req_last_1(l[1]),
    .o_rsp_valid_0(rv[0]), .o_rsp_valid_1(rv[1]),
    .o_rsp_rdata_0(rd0), .o_rsp_rdata_1(rd1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout), .o_busy(busy)
  );

  // read-first registered memory
  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
    if (pre_we) mem[pre_a] <= pre_d;
    else for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic idle_in();
    v = '0; l = '0; we = '0; a = '0; wd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0; idle_in();
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic preload(input logic [9:0] pa, input logic [31:0] pd);
    @(negedge clk); pre_we = 1'b1; pre_a = pa; pre_d = pd;
    @(negedge clk); pre_we = 1'b0;
  endtask

  typedef struct {int v0, v1, l0, l1, a0, a1, r0, r1, ewe, ea;} vec_t;
  vec_t tbl[19];
  int exp_seq[12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  int seq[$];
  logic [31:0] ref_mem [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, i1, m_own, m_cnt, m_last, o, eid;
    logic ep, bt;
    logic [31:0] edata;
    logic [1:0] hs;
    tbl = '{
      '{1,1,0,0,10,20,0,0, 0, 0}, '{1,1,0,0,10,20,1,0,15,10}, '{1,1,0,0,11,20,1,0,15,11},
      '{1,1,1,0,12,20,1,0,15,12}, '{1,1,0,0,13,20,0,1,15,20}, '{1,1,0,0,13,21,0,1,15,21},
      '{1,1,0,1,13,22,0,1,15,22}, '{1,1,1,0,13,23,1,0,15,13}, '{0,1,0,1,13,23,0,1,15,23},
      '{0,0,0,0, 0, 0,0,0, 0, 0}, '{1,1,0,0,14,24,0,0, 0, 0}, '{1,1,1,0,14,24,1,0,15,14},
      '{0,1,0,1,14,24,0,1,15,24}, '{1,0,0,0,15,0,0,0, 0, 0}, '{1,0,1,0,15, 0,1,0,15,15},
      '{1,1,1,1,16,26,0,0, 0, 0}, '{1,1,1,1,16,26,0,1,15,26}, '{1,0,1,0,16, 0,1,0,15,16},
      '{0,0,0,0, 0, 0,0,0, 0, 0}};
    idle_in();
    #2;
    chk("reset_ready", 32'(rdy), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_busy", 32'(busy), 0);
    nx(); rstn = 1'b1;
    foreach (tbl[k]) begin
      nx();
      v[0] = tbl[k].v0 != 0; v[1] = tbl[k].v1 != 0;
      l[0] = tbl[k].l0 != 0; l[1] = tbl[k].l1 != 0;
      a[0] = 10'(tbl[k].a0); a[1] = 10'(tbl[k].a1);
      we = {4'hF, 4'hF};
      wd[0] = {22'd0, a[0]}; wd[1] = {22'd0, a[1]};
      #1;
      chk($sformatf("tbl%0d_rdy0", k), 32'(rdy[0]), tbl[k].r0);
      chk($sformatf("tbl%0d_rdy1", k), 32'(rdy[1]), tbl[k].r1);
      chk($sformatf("tbl%0d_we", k), 32'(mem_we), tbl[k].ewe);
      chk($sformatf("tbl%0d_addr", k), 32'(mem_addr), tbl[k].ea);
      chk($sformatf("tbl%0d_din", k), mem_din, tbl[k].ea);
    end
    do_reset();
    preload(10'd5, 32'hDEADBEEF);
    nx(); v[0] = 1'b1; a[0] = 10'd5; we[0] = 4'h0; l[0] = 1'b1;
    #1 chk("rd_idle_rdy0", 32'(rdy[0]), 0);
    nx(); #1;
    chk("rd_grant_rdy0", 32'(rdy[0]), 1);
    chk("rd_mem_addr", 32'(mem_addr), 5);
    chk("rd_mem_we", 32'(mem_we), 0);
    nx(); v[0] = 1'b0; #1;
    chk("rd_rsp_valid0", 32'(rv[0]), 1);
    chk("rd_rsp_data0", rd0, 32'hDEADBEEF);
    chk("rd_rsp_valid1", 32'(rv[1]), 0);
    chk("rd_back_idle", 32'(rdy), 0);
    chk("rd_busy_pend", 32'(busy), 1);
    nx(); #1;
    chk("rd_rsp_gone", 32'(rv[0]), 0);
    chk("rd_rdata_zero", rd0, 0);
    chk("rd_busy_done", 32'(busy), 0);
    nx(); v[1] = 1'b1; we[1] = 4'hF; a[1] = 10'h3FF; wd[1] = 32'h12345678; l[1] = 1'b1;
    #1 chk("wr_idle_rdy1", 32'(rdy[1]), 0);
    nx(); #1;
    chk("wr_grant_rdy1", 32'(rdy[1]), 1);
    chk("wr_mem_we", 32'(mem_we), 32'hF);
    chk("wr_mem_din", mem_din, 32'h12345678);
    nx(); we[1] = 4'h0; #1;
    chk("wr_no_rsp", 32'(rv), 0);
    chk("wr_released", 32'(rdy[1]), 0);
    nx(); #1;
    chk("rb_addr", 32'(mem_addr), 32'h3FF);
    chk("rb_we", 32'(mem_we), 0);
    nx(); v[1] = 1'b0; #1;
    chk("rb_rsp_valid1", 32'(rv[1]), 1);
    chk("rb_rsp_data1", rd1, 32'h12345678);
    chk("rb_rsp_valid0", 32'(rv[0]), 0);
    i0 = 0; i1 = 0;
    for (int c = 0; c < 40; c++) begin
      nx();
      v[1] = i1 < 10; a[1] = 10'(100 + i1); we[1] = 4'hF; wd[1] = 32'(i1); l[1] = 1'b0;
      v[0] = c >= 1 && i0 < 2; a[0] = 10'(200 + i0); we[0] = 4'hF; wd[0] = 32'(i0); l[0] = i0 == 1;
      #1;
      chk("burst_one_owner", 32'(rdy[0] && rdy[1]), 0);
      if (v[1] && rdy[1]) begin chk("burst_addr1", 32'(mem_addr), 100 + i1); seq.push_back(1); i1++; end
      if (v[0] && rdy[0]) begin chk("burst_addr0", 32'(mem_addr), 200 + i0); seq.push_back(0); i0++; end
    end
    chk("burst_r1_beats", i1, 10);
    chk("burst_r0_beats", i0, 2);
    chk("burst_total", seq.size(), 12);
    for (int k = 0; k < 12; k++) if (k < seq.size()) chk($sformatf("burst_order%0d", k), seq[k], exp_seq[k]);
    do_reset();
    nx(); v = 2'b11; a[0] = 10'd50; a[1] = 10'd60; we = {4'hF, 4'hF}; l = 2'b10; #1;
    nx(); #1;
    chk("stall_grant0", 32'(rdy), 32'b01);
    chk("stall_first_addr", 32'(mem_addr), 50);
    for (int k = 0; k < 5; k++) begin
      nx(); v[0] = 1'b0; #1;
      chk("stall_rdy", 32'(rdy), 32'b01);
      chk("stall_we", 32'(mem_we), 0);
      chk("stall_addr", 32'(mem_addr), 0);
    end
    nx(); v[0] = 1'b1; a[0] = 10'd51; l[0] = 1'b1; #1;
    chk("stall_last_addr", 32'(mem_addr), 51);
    nx(); v[0] = 1'b0; #1;
    chk("stall_handover", 32'(rdy), 32'b10);
    chk("stall_r1_addr", 32'(mem_addr), 60);
    nx(); idle_in(); #1;
    nx(); v[1] = 1'b1; we[1] = 4'h0; a[1] = 10'd7; #1;
    nx(); #1 chk("rst_owner1", 32'(rdy[1]), 1);
    @(posedge clk); #2;
    chk("rst_rsp_pending", 32'(rv[1]), 1);
    rstn = 1'b0; #1;
    chk("rst_async_rdy", 32'(rdy), 0);
    chk("rst_async_rv", 32'(rv), 0);
    chk("rst_async_rdata", rd1, 0);
    chk("rst_async_mem", 32'(mem_addr) | 32'(mem_we), 0);
    chk("rst_async_busy", 32'(busy), 0);
    nx(); #1 chk("rst_no_rsp", 32'(rv), 0);
    nx(); rstn = 1'b1; v = 2'b11; we = '0; a = '0; #1;
    chk("rst_after_rv", 32'(rv), 0);
    nx(); #1 chk("rst_tie_r0", 32'(rdy), 32'b01);
    do_reset();
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      preload(10'(k), ref_mem[k]);
    end
    m_own = -1; m_cnt = 0; m_last = 1; ep = 1'b0; eid = 0; edata = '0; hs = '0;
    for (int c = 0; c < 2000; c++) begin
      nx();
      for (int n = 0; n < 2; n++)
        if (!v[n] || hs[n]) begin
          v[n] = $urandom_range(0, 3) != 0;
          we[n] = $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'h0;
          a[n] = 10'($urandom_range(0, 15));
          wd[n] = $urandom;
          l[n] = $urandom_range(0, 3) == 0;
        end
      #1;
      o = m_own < 0 ? 0 : m_own;
      bt = m_own >= 0 && v[o];
      chk("rnd_rdy0", 32'(rdy[0]), 32'(m_own == 0));
      chk("rnd_rdy1", 32'(rdy[1]), 32'(m_own == 1));
      chk("rnd_mem_we", 32'(mem_we), bt ? 32'(we[o]) : 0);
      chk("rnd_mem_addr", 32'(mem_addr), bt ? 32'(a[o]) : 0);
      chk("rnd_mem_din", mem_din, bt ? wd[o] : 0);
      chk("rnd_rsp_valid0", 32'(rv[0]), 32'(ep && eid == 0));
      chk("rnd_rsp_valid1", 32'(rv[1]), 32'(ep && eid == 1));
      chk("rnd_rsp_data0", rd0, (ep && eid == 0) ? edata : 0);
      chk("rnd_rsp_data1", rd1, (ep && eid == 1) ? edata : 0);
      hs = v & rdy;
      ep = bt && we[o] == 4'h0;
      eid = o;
      edata = ref_mem[a[o][3:0]];
      if (bt) for (int b = 0; b < 4; b++) if (we[o][b]) ref_mem[a[o][3:0]][8*b +: 8] = wd[o][8*b +: 8];
      if (m_own < 0) m_own = (v[0] && v[1]) ? 1 - m_last : v[0] ? 0 : v[1] ? 1 : -1;
      else if (bt) begin
        m_cnt++;
        if (l[o] || m_cnt == MB) begin
          m_last = o; m_cnt = 0;
          m_own = v[1 - o] ? 1 - o : -1;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
